// File: rtl/count_ctrl.sv
// rtl/count_ctrl.sv - countdown display controller: 7..0 count with pause, restart and hold-in-done.
module count_ctrl #(
  parameter int TICK_DIV   = 1000,
  parameter int HOLD_TICKS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_pause,
  output logic [2:0] num,
  output logic       st,
  output logic       done,
  output logic       busy
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [3:0]    HOLD_LAST = 4'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_PAUSE, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [2:0]    num_q, num_d;
  logic          st_q, st_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    hold_q, hold_d;
  logic          start_q, pause_q;
  // armed_q masks edges for the first cycle after reset, so a button held
  // through reset release is seen as already pressed rather than as a new press.
  logic          armed_q;

  logic start_p, pause_p, tick;

  always_comb begin
    start_p = btn_start & ~start_q & armed_q;
    pause_p = btn_pause & ~pause_q & armed_q;
    tick    = (presc_q == PRESC_MAX);

    state_d = state_q;
    num_d   = num_q;
    presc_d = presc_q;
    hold_d  = hold_q;
    done_d  = 1'b0;

    if (state_q == S_COUNT || state_q == S_DONE)
      presc_d = tick ? '0 : presc_q + 1'b1;

    if (start_p) begin
      state_d = S_COUNT;
      num_d   = 3'd7;
      presc_d = '0;
      hold_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: num_d = 3'd7;
        S_COUNT: begin
          if (tick && num_q == 3'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = '0;
          end else begin
            if (tick) num_d = num_q - 3'd1;
            if (pause_p) state_d = S_PAUSE;
          end
        end
        S_PAUSE: if (pause_p) state_d = S_COUNT;
        S_DONE: begin
          if (tick) begin
            if (hold_q == HOLD_LAST) begin
              state_d = S_IDLE;
              num_d   = 3'd7;
              hold_d  = '0;
            end else begin
              hold_d = hold_q + 4'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    st_d   = (state_d != S_IDLE);
    busy_d = (state_d == S_COUNT) || (state_d == S_PAUSE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      num_q   <= 3'd7;
      st_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      presc_q <= '0;
      hold_q  <= '0;
      start_q <= 1'b0;
      pause_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      st_q    <= st_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      presc_q <= presc_d;
      hold_q  <= hold_d;
      start_q <= btn_start;
      pause_q <= btn_pause;
      armed_q <= 1'b1;
    end
  end

  assign num  = num_q;
  assign st   = st_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_count_ctrl.sv
// tb/tb_count_ctrl.sv - directed bench for count_ctrl with TICK_DIV=4, HOLD_TICKS=2.
module tb_count_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_start;
  logic       btn_pause;
  logic [2:0] num;
  logic       st;
  logic       done;
  logic       busy;

  int total_checks;
  int failed_checks;

  count_ctrl #(.TICK_DIV(4), .HOLD_TICKS(2)) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_pause(btn_pause),
    .num(num), .st(st), .done(done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total_checks++;
    assert (obs === exp) else begin
      failed_checks++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press_start();
    btn_start = 1'b1;
    @(negedge clk);
    btn_start = 1'b0;
  endtask

  task automatic press_pause();
    btn_pause = 1'b1;
    @(negedge clk);
    btn_pause = 1'b0;
  endtask

  initial begin
    int exp_num;
    total_checks  = 0;
    failed_checks = 0;
    rst       = 1'b0;
    btn_start = 1'b0;
    btn_pause = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk("reset_num", num, 7);
    chk("reset_st", st, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    repeat (3) @(negedge clk);
    chk("idle_wait_st", st, 0);

    // full countdown: edge 0 is the start press
    press_start();
    chk("run_st_c1", st, 1);
    chk("run_busy_c1", busy, 1);
    chk("run_num_c1", num, 7);
    for (int k = 1; k <= 42; k++) begin
      @(negedge clk);
      exp_num = (k < 28) ? 7 - k / 4 : ((k < 40) ? 0 : 7);
      chk($sformatf("run_num_c%0d", k), num, exp_num);
      chk($sformatf("run_done_c%0d", k), done, (k == 32) ? 1 : 0);
      chk($sformatf("run_st_c%0d", k), st, (k < 40) ? 1 : 0);
      chk($sformatf("run_busy_c%0d", k), busy, (k < 32) ? 1 : 0);
    end

    // pause at edge 6, resume at edge 20
    press_start();
    repeat (5) @(negedge clk);
    press_pause();
    chk("pause_num_c6", num, 6);
    chk("pause_busy_c6", busy, 1);
    for (int k = 7; k <= 19; k++) begin
      @(negedge clk);
      chk($sformatf("pause_hold_c%0d", k), num, 6);
      chk($sformatf("pause_st_c%0d", k), st, 1);
    end
    press_pause();
    chk("resume_num_c20", num, 6);
    @(negedge clk);
    chk("resume_num_c21", num, 6);
    @(negedge clk);
    chk("resume_num_c22", num, 5);

    // restart while num is 3
    repeat (9) @(negedge clk);
    chk("pre_restart_num", num, 3);
    press_start();
    chk("restart_num", num, 7);
    chk("restart_busy", busy, 1);
    repeat (3) @(negedge clk);
    chk("restart_num_c3", num, 7);
    @(negedge clk);
    chk("restart_num_c4", num, 6);

    // start and pause together: start wins, counting continues
    btn_start = 1'b1;
    btn_pause = 1'b1;
    @(negedge clk);
    btn_start = 1'b0;
    btn_pause = 1'b0;
    chk("both_num", num, 7);
    chk("both_busy", busy, 1);
    repeat (3) @(negedge clk);
    chk("both_num_c3", num, 7);
    @(negedge clk);
    chk("both_num_c4", num, 6);

    // reset at num==2 with btn_start held through release
    repeat (17) @(negedge clk);
    chk("prerst_num", num, 2);
    rst       = 1'b0;
    btn_start = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    chk("midrst_num", num, 7);
    chk("midrst_st", st, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk($sformatf("held_st_c%0d", k), st, 0);
      chk($sformatf("held_done_c%0d", k), done, 0);
    end
    btn_start = 1'b0;
    repeat (2) @(negedge clk);

    // held start: exactly one restart
    btn_start = 1'b1;
    @(negedge clk);
    chk("hold_st_c0", st, 1);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k % 4 == 0)
        chk($sformatf("hold_num_c%0d", k), num, 7 - k / 4);
    end
    btn_start = 1'b0;
    repeat (20) @(negedge clk);
    chk("hold_idle_st", st, 0);
    chk("hold_idle_num", num, 7);

    // pause in IDLE ignored
    press_pause();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("idle_pause_st_c%0d", k), st, 0);
      chk($sformatf("idle_pause_busy_c%0d", k), busy, 0);
      chk($sformatf("idle_pause_num_c%0d", k), num, 7);
    end

    $display("%0d/%0d checks passed", total_checks - failed_checks, total_checks);
    $finish;
  end

endmodule
